// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for waveform generators: state encoding and phase-length clamp.
package pulse_train_gen_pkg;

  localparam logic [1:0] ST_IDLE_C = 2'd0;
  localparam logic [1:0] ST_HIGH_C = 2'd1;
  localparam logic [1:0] ST_LOW_C  = 2'd2;
  localparam logic [1:0] ST_DONE_C = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE_C,
    S_HIGH = ST_HIGH_C,
    S_LOW  = ST_LOW_C,
    S_DONE = ST_DONE_C
  } ptg_state_e;

  // A zero-length phase is stretched to one clock so every pulse has a visible edge.
  function automatic logic [31:0] clamp_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle of the pulse train generator.
interface pulse_train_gen_if #(
  parameter int CntBits = 16,
  parameter int NumBits = 8
) ();
  logic               Start;
  logic               Abort;
  logic [CntBits-1:0] HighCycles;
  logic [CntBits-1:0] LowCycles;
  logic [NumBits-1:0] PulseNum;
  logic               PulseOut;
  logic               Busy;
  logic               Done;
  logic [NumBits-1:0] PulseCnt;

  modport master (
    output Start, Abort, HighCycles, LowCycles, PulseNum,
    input  PulseOut, Busy, Done, PulseCnt
  );

  modport slave (
    input  Start, Abort, HighCycles, LowCycles, PulseNum,
    output PulseOut, Busy, Done, PulseCnt
  );
endinterface

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable down-counter that times one phase; Zero marks the last clock of the phase.
module pulse_train_gen_phase_timer #(
  parameter int CntBits = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Load,
  input  logic [CntBits-1:0] LoadValue,
  output logic               Zero
);

  logic [CntBits-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero (never wraps).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (Load) begin
      cnt_q <= LoadValue;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntBits'(1);
    end
  end

  assign Zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: N pulses of H clocks high and L clocks low per Start.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CntBits = 16,
  parameter int NumBits = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  pulse_train_gen_if.slave bus
);

  ptg_state_e         state_q;
  logic               pulse_q;
  logic               busy_q;
  logic               done_q;
  logic [NumBits-1:0] cnt_q;
  logic [NumBits-1:0] num_q;
  logic [CntBits-1:0] hi_q;
  logic [CntBits-1:0] lo_q;

  logic               start_ok;
  logic [CntBits-1:0] hi_start;
  logic [CntBits-1:0] lo_start;
  logic               tmr_load;
  logic [CntBits-1:0] tmr_val;
  logic               tmr_zero;

  // Timer reload values are the clamped phase lengths minus one.
  assign hi_start = CntBits'(clamp_len(32'(bus.HighCycles)) - 32'd1);
  assign lo_start = CntBits'(clamp_len(32'(bus.LowCycles)) - 32'd1);
  assign start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.Start && !bus.Abort;

  // Reload the phase timer on every phase entry.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok && (bus.PulseNum != '0)) begin
          tmr_load = 1'b1;
          tmr_val  = hi_start;
        end
      end
      S_HIGH: begin
        if (!bus.Abort && tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = lo_q;
        end
      end
      S_LOW: begin
        if (!bus.Abort && tmr_zero && (cnt_q != num_q)) begin
          tmr_load = 1'b1;
          tmr_val  = hi_q;
        end
      end
      default: ;
    endcase
  end

  pulse_train_gen_phase_timer #(.CntBits(CntBits)) u_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (tmr_load),
    .LoadValue (tmr_val),
    .Zero      (tmr_zero)
  );

  // Burst FSM with registered outputs; config latches are data and skip reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
          if (start_ok) begin
            cnt_q <= '0;
            num_q <= bus.PulseNum;
            hi_q  <= hi_start;
            lo_q  <= lo_start;
            if (bus.PulseNum != '0) begin
              state_q <= S_HIGH;
              pulse_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (bus.Abort) begin
            state_q <= S_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tmr_zero) begin
            state_q <= S_LOW;
            pulse_q <= 1'b0;
            cnt_q   <= cnt_q + NumBits'(1);
          end
        end
        S_LOW: begin
          if (bus.Abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (tmr_zero) begin
            if (cnt_q == num_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_HIGH;
              pulse_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.PulseOut = pulse_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.PulseCnt = cnt_q;

endmodule
